// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lock_pkg
// Brief    : Shared lock-state encodings, default combination and the
//            panel-arbiter state type, used by the lock and by
//            lock_panel_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package lock_pkg;

  // Encodings of the lock's own state register (seen as lock_state).
  localparam logic [2:0] CLOSED  = 3'b000;
  localparam logic [2:0] CLOSED2 = 3'b001;
  localparam logic [2:0] OPEN    = 3'b010;
  localparam logic [2:0] ALARM   = 3'b011;
  localparam logic [2:0] NEW     = 3'b100;

  // Combination the lock starts out with.
  localparam logic [3:0] DEFAULT_COMBO = 4'b0110;

  // Panel arbiter session states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2,
    LOCKOUT = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/lock_panel_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : lock_panel_arbiter_if
// Brief    : Keypad-panel side and lock side signals of the panel arbiter.
//            master = panels/lock environment, slave = the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface lock_panel_arbiter_if;

  logic [1:0] req;
  logic [3:0] code0;
  logic [3:0] code1;
  logic [1:0] enter_in;
  logic [1:0] change_in;
  logic [2:0] lock_state;
  logic [3:0] X;
  logic       enterPulse;
  logic       changePulse;
  logic [1:0] grant;
  logic       busy;
  logic       timeout_flag;
  logic       lockout;

  modport master (
    output req, code0, code1, enter_in, change_in, lock_state,
    input  X, enterPulse, changePulse, grant, busy, timeout_flag, lockout
  );

  modport slave (
    input  req, code0, code1, enter_in, change_in, lock_state,
    output X, enterPulse, changePulse, grant, busy, timeout_flag, lockout
  );

endinterface
`default_nettype wire

// File: rtl/lock_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : lock_rr_pick
// Brief    : Two-requester round-robin select. o_pick is one-hot (00 when
//            nobody requests). The pointer names the panel preferred on the
//            next contention and flips only when a contention is resolved.
// Revision : 1.0 - initial release
// ============================================================================
module lock_rr_pick (
  input  wire logic       Clock,
  input  wire logic       Resetn,
  input  wire logic [1:0] i_req,
  input  wire logic       i_advance,
  output logic      [1:0] o_pick
);

  logic r_ptr;

  // Pointer moves to the other panel after it has been used to break a tie.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_ptr <= 1'b0;
    end else if (i_advance && (i_req == 2'b11)) begin
      r_ptr <= ~r_ptr;
    end
  end

  // A single requester always wins; a tie goes to the preferred panel.
  always_comb begin
    o_pick = 2'b00;
    case (i_req)
      2'b01:   o_pick = 2'b01;
      2'b10:   o_pick = 2'b10;
      2'b11:   o_pick = r_ptr ? 2'b10 : 2'b01;
      default: o_pick = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lock_panel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lock_panel_arbiter
// Brief    : Grants one of two keypad panels ownership of the single lock
//            datapath and forwards only the owner's code and pulses.
//            Sessions end on release, idle timeout or alarm; alarm blocks
//            grants until the lock leaves ALARM.
//            Build option LOCK_FIXED_PRIO_EN: panel 0 always wins a tie and
//            the round-robin pointer is not built.
// Revision : 1.0 - initial release
// ============================================================================
module lock_panel_arbiter
  import lock_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input wire logic             Clock,
  input wire logic             Resetn,
  lock_panel_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_idle_last = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_idle_max  = '1;

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [1:0]       r_grant,    w_grant_nxt;
  logic [3:0]       r_x,        w_x_nxt;
  logic             r_enter,    w_enter_nxt;
  logic             r_change,   w_change_nxt;
  logic             r_timeout,  w_timeout_nxt;
  logic             r_lockout,  w_lockout_nxt;
  logic             r_busy,     w_busy_nxt;
  logic [CNT_W-1:0] r_idle_cnt, w_idle_cnt_nxt;

  logic [1:0] w_pick;
  logic       w_sel;
  logic       w_own_req;
  logic [3:0] w_own_code;
  logic       w_own_enter;
  logic       w_own_change;
  logic       w_own_pulse;
  logic       w_alarm;

`ifdef LOCK_FIXED_PRIO_EN
  // Panel 0 always wins a tie.
  assign w_pick = bus.req[0] ? 2'b01 : (bus.req[1] ? 2'b10 : 2'b00);
`else
  logic w_rr_adv;

  // A pick is consumed only when IDLE actually grants (no alarm pending).
  assign w_rr_adv = (r_state == IDLE) && !w_alarm;

  lock_rr_pick u_rr_pick (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .i_req     (bus.req),
    .i_advance (w_rr_adv),
    .o_pick    (w_pick)
  );
`endif

  // Owner-side view: panel 1 owns when grant[1] is set, else panel 0.
  assign w_sel        = r_grant[1];
  assign w_own_req    = w_sel ? bus.req[1]       : bus.req[0];
  assign w_own_code   = w_sel ? bus.code1        : bus.code0;
  assign w_own_enter  = w_sel ? bus.enter_in[1]  : bus.enter_in[0];
  assign w_own_change = w_sel ? bus.change_in[1] : bus.change_in[0];
  assign w_own_pulse  = w_own_enter | w_own_change;
  assign w_alarm      = (bus.lock_state == ALARM);

  // State and every output are registered together.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state    <= IDLE;
      r_grant    <= 2'b00;
      r_x        <= 4'b0000;
      r_enter    <= 1'b0;
      r_change   <= 1'b0;
      r_timeout  <= 1'b0;
      r_lockout  <= 1'b0;
      r_busy     <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_x        <= w_x_nxt;
      r_enter    <= w_enter_nxt;
      r_change   <= w_change_nxt;
      r_timeout  <= w_timeout_nxt;
      r_lockout  <= w_lockout_nxt;
      r_busy     <= w_busy_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
    end
  end

  // Next state and next output values; pulses and flags default low, X holds.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_x_nxt        = r_x;
    w_enter_nxt    = 1'b0;
    w_change_nxt   = 1'b0;
    w_timeout_nxt  = 1'b0;
    w_lockout_nxt  = 1'b0;
    w_idle_cnt_nxt = r_idle_cnt;

    case (r_state)
      IDLE: begin
        if (w_alarm) begin
          w_state_nxt   = LOCKOUT;
          w_grant_nxt   = 2'b00;
          w_lockout_nxt = 1'b1;
        end else if (w_pick != 2'b00) begin
          w_state_nxt    = OWN;
          w_grant_nxt    = w_pick;
          w_idle_cnt_nxt = '0;
        end
      end

      OWN: begin
        if (w_alarm) begin
          // Alarm cuts the session at once; nothing from this cycle passes.
          w_state_nxt   = LOCKOUT;
          w_grant_nxt   = 2'b00;
          w_lockout_nxt = 1'b1;
        end else if (!w_own_req) begin
          // A pulse arriving with the release is still delivered.
          w_state_nxt  = RELEASE;
          w_grant_nxt  = 2'b00;
          w_x_nxt      = w_own_code;
          w_enter_nxt  = w_own_enter;
          w_change_nxt = w_own_change;
        end else if ((r_idle_cnt == c_idle_last) && !w_own_pulse) begin
          w_state_nxt   = RELEASE;
          w_grant_nxt   = 2'b00;
          w_timeout_nxt = 1'b1;
        end else begin
          w_x_nxt      = w_own_code;
          w_enter_nxt  = w_own_enter;
          w_change_nxt = w_own_change;
          if (w_own_pulse) begin
            w_idle_cnt_nxt = '0;
          end else if (r_idle_cnt != c_idle_max) begin
            w_idle_cnt_nxt = r_idle_cnt + 1'b1;
          end
        end
      end

      RELEASE: begin
        // Mandatory one-cycle gap; requests are not looked at here.
        w_state_nxt = IDLE;
        w_grant_nxt = 2'b00;
      end

      LOCKOUT: begin
        w_grant_nxt = 2'b00;
        if (w_alarm) begin
          w_lockout_nxt = 1'b1;
        end else begin
          w_state_nxt = RELEASE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = 2'b00;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign bus.X            = r_x;
  assign bus.enterPulse   = r_enter;
  assign bus.changePulse  = r_change;
  assign bus.grant        = r_grant;
  assign bus.busy         = r_busy;
  assign bus.timeout_flag = r_timeout;
  assign bus.lockout      = r_lockout;

endmodule
`default_nettype wire

// File: tb/tb_lock_panel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_panel_arbiter
// Brief    : Self-checking bench for lock_panel_arbiter (TIMEOUT_CYCLES=8).
//            Each driven cycle pushes the expected registered outputs; a
//            monitor pops and compares them after the next rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lock_panel_arbiter;
  import lock_pkg::*;

  typedef struct {
    string      tag;
    logic [1:0] g;
    logic [3:0] x;
    logic       e;
    logic       c;
    logic       t;
    logic       l;
    logic       b;
  } exp_t;

  logic Clock;
  logic Resetn;
  int   n_total = 0;
  int   n_bad   = 0;
  exp_t exp_q[$];

  lock_panel_arbiter_if bus ();

  lock_panel_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue what must appear
  // on the outputs after the following rising edge.
  task automatic cyc(input string tag, input logic [1:0] rq, input logic [3:0] c0,
                     input logic [3:0] c1, input logic [1:0] en, input logic [1:0] ch,
                     input logic [2:0] ls, input logic [1:0] eg, input logic [3:0] ex,
                     input logic ee, input logic ec, input logic et, input logic el,
                     input logic eb);
    exp_t e;
    @(negedge Clock);
    bus.req        = rq;
    bus.code0      = c0;
    bus.code1      = c1;
    bus.enter_in   = en;
    bus.change_in  = ch;
    bus.lock_state = ls;
    e.tag = tag; e.g = eg; e.x = ex; e.e = ee; e.c = ec; e.t = et; e.l = el; e.b = eb;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".grant"},   32'(bus.grant),        32'h0);
    chk({tag, ".X"},       32'(bus.X),            32'h0);
    chk({tag, ".enter"},   32'(bus.enterPulse),   32'h0);
    chk({tag, ".change"},  32'(bus.changePulse),  32'h0);
    chk({tag, ".busy"},    32'(bus.busy),         32'h0);
    chk({tag, ".timeout"}, 32'(bus.timeout_flag), 32'h0);
    chk({tag, ".lockout"}, 32'(bus.lockout),      32'h0);
  endtask

  // Scoreboard side: compare queued expectations just after each rising edge.
  always @(posedge Clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.tag, ".grant"},   32'(bus.grant),        32'(e.g));
      chk({e.tag, ".X"},       32'(bus.X),            32'(e.x));
      chk({e.tag, ".enter"},   32'(bus.enterPulse),   32'(e.e));
      chk({e.tag, ".change"},  32'(bus.changePulse),  32'(e.c));
      chk({e.tag, ".timeout"}, 32'(bus.timeout_flag), 32'(e.t));
      chk({e.tag, ".lockout"}, 32'(bus.lockout),      32'(e.l));
      chk({e.tag, ".busy"},    32'(bus.busy),         32'(e.b));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [1:0] rr_g;
    logic [3:0] rr_x;
    logic       rr_c;
`ifdef LOCK_FIXED_PRIO_EN
    rr_g = 2'b01; rr_x = 4'h2; rr_c = 1'b0;
`else
    rr_g = 2'b10; rr_x = 4'h8; rr_c = 1'b1;
`endif

    Resetn         = 1'b0;
    bus.req        = 2'b00;
    bus.code0      = 4'h0;
    bus.code1      = 4'h0;
    bus.enter_in   = 2'b00;
    bus.change_in  = 2'b00;
    bus.lock_state = CLOSED;
    #12;
    chk_reset_outputs("reset");
    @(negedge Clock);
    Resetn = 1'b1;

    // Cycles 1-4 idle, request at cycle 5, enter at cycle 8.
    for (int i = 0; i < 4; i++)
      cyc("idle", 2'b00, 4'h0, 4'h0, 2'b00, 2'b00, CLOSED, 2'b00, 4'h0, 0, 0, 0, 0, 0);
    cyc("grant0",     2'b01, 4'h0, 4'h0, 2'b00, 2'b00, CLOSED, 2'b01, 4'h0, 0, 0, 0, 0, 1);
    cyc("own0a",      2'b01, 4'h0, 4'h0, 2'b00, 2'b00, CLOSED, 2'b01, 4'h0, 0, 0, 0, 0, 1);
    cyc("own0b",      2'b01, 4'h0, 4'h0, 2'b00, 2'b00, CLOSED, 2'b01, 4'h0, 0, 0, 0, 0, 1);
    cyc("enter0",     2'b01, 4'h6, 4'h0, 2'b01, 2'b00, CLOSED, 2'b01, 4'h6, 1, 0, 0, 0, 1);
    cyc("post_enter", 2'b01, 4'h6, 4'h0, 2'b00, 2'b00, CLOSED, 2'b01, 4'h6, 0, 0, 0, 0, 1);
    cyc("nonowner",   2'b01, 4'hA, 4'hF, 2'b10, 2'b00, CLOSED, 2'b01, 4'hA, 0, 0, 0, 0, 1);
    cyc("change0",    2'b01, 4'h3, 4'hF, 2'b00, 2'b01, CLOSED, 2'b01, 4'h3, 0, 1, 0, 0, 1);
    cyc("both",       2'b01, 4'h5, 4'hF, 2'b01, 2'b01, CLOSED, 2'b01, 4'h5, 1, 1, 0, 0, 1);
    cyc("drop_pulse", 2'b00, 4'h9, 4'hF, 2'b01, 2'b00, CLOSED, 2'b00, 4'h9, 1, 0, 0, 0, 1);
    cyc("gap1",       2'b11, 4'h9, 4'hF, 2'b00, 2'b00, CLOSED, 2'b00, 4'h9, 0, 0, 0, 0, 0);
    // Contention with pointer at panel 0, then owner releases.
    cyc("rr_first",   2'b11, 4'h9, 4'hF, 2'b00, 2'b00, CLOSED, 2'b01, 4'h9, 0, 0, 0, 0, 1);
    cyc("own_rr",     2'b11, 4'h0, 4'hF, 2'b00, 2'b00, CLOSED, 2'b01, 4'h0, 0, 0, 0, 0, 1);
    cyc("drop0",      2'b10, 4'h0, 4'hF, 2'b00, 2'b00, CLOSED, 2'b00, 4'h0, 0, 0, 0, 0, 1);
    cyc("gap2",       2'b10, 4'h0, 4'hC, 2'b00, 2'b00, CLOSED, 2'b00, 4'h0, 0, 0, 0, 0, 0);
    cyc("regrant1",   2'b10, 4'h0, 4'hC, 2'b00, 2'b00, CLOSED, 2'b10, 4'h0, 0, 0, 0, 0, 1);
    // Panel 1 stays silent: 8th idle cycle ends the session by timeout.
    for (int i = 0; i < 7; i++)
      cyc("idle_own", 2'b10, 4'h0, 4'hC, (i == 2) ? 2'b01 : 2'b00, 2'b00, CLOSED,
          2'b10, 4'hC, 0, 0, 0, 0, 1);
    cyc("timeout",    2'b10, 4'h0, 4'hC, 2'b00, 2'b00, CLOSED, 2'b00, 4'hC, 0, 0, 1, 0, 1);
    cyc("after_to",   2'b00, 4'h0, 4'hC, 2'b00, 2'b00, CLOSED, 2'b00, 4'hC, 0, 0, 0, 0, 0);
    cyc("idle2",      2'b00, 4'h0, 4'hC, 2'b00, 2'b00, CLOSED, 2'b00, 4'hC, 0, 0, 0, 0, 0);
    // Alarm during a session.
    cyc("grant0b",    2'b01, 4'h2, 4'hC, 2'b00, 2'b00, CLOSED, 2'b01, 4'hC, 0, 0, 0, 0, 1);
    cyc("own0c",      2'b01, 4'h2, 4'hC, 2'b00, 2'b00, CLOSED, 2'b01, 4'h2, 0, 0, 0, 0, 1);
    cyc("alarm",      2'b01, 4'hF, 4'hC, 2'b01, 2'b00, ALARM,  2'b00, 4'h2, 0, 0, 0, 1, 1);
    cyc("lockout",    2'b01, 4'hF, 4'hC, 2'b01, 2'b01, ALARM,  2'b00, 4'h2, 0, 0, 0, 1, 1);
    cyc("unlock",     2'b01, 4'hF, 4'hC, 2'b00, 2'b00, CLOSED, 2'b00, 4'h2, 0, 0, 0, 0, 1);
    cyc("gap3",       2'b01, 4'hF, 4'hC, 2'b00, 2'b00, CLOSED, 2'b00, 4'h2, 0, 0, 0, 0, 0);
    cyc("grant0c",    2'b01, 4'h2, 4'hC, 2'b00, 2'b00, CLOSED, 2'b01, 4'h2, 0, 0, 0, 0, 1);
    cyc("drop0c",     2'b00, 4'h2, 4'hC, 2'b00, 2'b00, CLOSED, 2'b00, 4'h2, 0, 0, 0, 0, 1);
    // Alarm seen in IDLE beats a pending request.
    cyc("gap4",       2'b11, 4'h2, 4'hC, 2'b00, 2'b00, ALARM,  2'b00, 4'h2, 0, 0, 0, 0, 0);
    cyc("idle_alarm", 2'b11, 4'h2, 4'hC, 2'b00, 2'b00, ALARM,  2'b00, 4'h2, 0, 0, 0, 1, 1);
    cyc("unlock2",    2'b11, 4'h2, 4'hC, 2'b00, 2'b00, CLOSED, 2'b00, 4'h2, 0, 0, 0, 0, 1);
    cyc("gap5",       2'b11, 4'h2, 4'hC, 2'b00, 2'b00, CLOSED, 2'b00, 4'h2, 0, 0, 0, 0, 0);
    // Second contention: pointer now prefers panel 1.
    cyc("rr_second",  2'b11, 4'h2, 4'hC, 2'b00, 2'b00, CLOSED, rr_g,  4'h2, 0, 0, 0, 0, 1);
    cyc("change1",    2'b11, 4'h2, 4'h8, 2'b00, 2'b10, CLOSED, rr_g,  rr_x, 0, rr_c, 0, 0, 1);

    // Asynchronous reset between edges while a session is open.
    @(negedge Clock);
    #2;
    Resetn        = 1'b0;
    bus.req       = 2'b00;
    bus.enter_in  = 2'b00;
    bus.change_in = 2'b00;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge Clock);
    Resetn = 1'b1;

    // Pointer is back at panel 0 after reset.
    cyc("rr_reset",   2'b11, 4'h0, 4'h0, 2'b00, 2'b00, CLOSED, 2'b01, 4'h0, 0, 0, 0, 0, 1);

    @(posedge Clock);
    #2;
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lock_panel_arbiter.md
Name: lock_panel_arbiter

Overview:
Shares the single combination-lock datapath between two keypad panels. Each panel supplies a 4-bit code and its own enter/change pulses. One panel at a time is granted ownership, and only the owner's code and pulses are forwarded to the lock. Sessions end on release, inactivity timeout or alarm, and alarm blocks all further grants until the lock leaves ALARM.

Parameters:
TIMEOUT_CYCLES, 1000, consecutive owner-idle cycles (no forwarded pulse) before the session is forcibly ended; legal range ≥ 2.
CNT_W, $clog2(TIMEOUT_CYCLES+1), idle-counter width (derived, not overridden).

Ports:
Clock  input  1  system clock, rising edge
Resetn  input  1  asynchronous active-low reset
req  input  2  per-panel session request, level, bit i = panel i
code0  input  4  panel 0 code switches
code1  input  4  panel 1 code switches
enter_in  input  2  per-panel enter pulse, 1 cycle wide
change_in  input  2  per-panel change pulse, 1 cycle wide
lock_state  input  3  current lock state register from the lock
X  output  4  code presented to the lock
enterPulse  output  1  forwarded enter pulse
changePulse  output  1  forwarded change pulse
grant  output  2  one-hot owner, 00 = none
busy  output  1  high when state ≠ IDLE
timeout_flag  output  1  1-cycle pulse when a session ends by timeout
lockout  output  1  high while in LOCKOUT

Behaviour:
- Reset (async, Resetn=0). State=IDLE, grant=00, X=0000, enterPulse=0, changePulse=0, busy=0, timeout_flag=0, lockout=0, idle counter=0, rr pointer=panel 0 (panel 0 preferred next).
- States: IDLE, OWN, RELEASE, LOCKOUT. All outputs are registered.
- IDLE:
  - If lock_state==ALARM, go to LOCKOUT. This has priority over any request.
  - If exactly one req bit is set, grant that panel.
  - If both are set, grant the panel the rr pointer prefers; the pointer then flips to the other panel.
  - grant asserts the cycle after req is sampled.
- OWN:
  - Each cycle, register X <= owner code, enterPulse <= owner enter_in, changePulse <= owner change_in. Latency is 1 cycle, and X is always updated on the same edge as the pulse, so X is valid when the pulse is high.
  - The non-owner's pulses are dropped, not queued.
  - The idle counter clears on any owner pulse and otherwise increments.
- OWN exit conditions, checked in priority order:
  1. lock_state==ALARM → LOCKOUT.
  2. The owner's req drops → RELEASE.
  3. The idle counter reaches TIMEOUT_CYCLES-1 with no pulse this cycle → RELEASE, with timeout_flag=1 for one cycle.
- On exit from OWN: grant=00 on the next cycle, forwarded pulses are forced to 0, and X holds its last value.
- RELEASE: a single mandatory gap cycle, then IDLE. Requests are ignored here, so the earliest regrant is 2 cycles after release.
- LOCKOUT: lockout=1, grant=00, pulses=0. Stay until lock_state≠ALARM, then go to RELEASE.
- Simultaneous owner pulse and req drop in the same cycle: the pulse is still forwarded, then the session releases.
- A pulse on both enter_in and change_in of the owner in the same cycle: both are forwarded unchanged (the lock gives enter priority).
- Idle counter saturates and never wraps.

Optional Feature:
LOCK_FIXED_PRIO_EN
- Defined: fixed priority. When both panels request, panel 0 always wins and the rr pointer is removed.
- Undefined: round-robin as specified above.
- All other behaviour is identical either way.

Decomposition:
- Package lock_pkg holds:
  - lock state encodings: CLOSED=3'b000, CLOSED2=3'b001, OPEN=3'b010, ALARM=3'b011, NEW=3'b100;
  - arbiter state typedef;
  - DEFAULT_COMBO=4'b0110.
- The lock block and this arbiter both import lock_pkg.
- One natural sub-module: lock_rr_pick (2-requester round-robin select plus pointer).

Test Plan:
- Reset, then req=01 at cycle 5 → grant=01 at cycle 6. Then code0=0110 with enter_in[0] at cycle 8 → X=0110 and enterPulse=1 at cycle 9 only.
- req=11 from IDLE, pointer=0 → grant=01. Drop req[0] → grant=00 for one cycle (RELEASE), then grant=10 two cycles after release.
- Panel 1 pulses enter_in[1] while panel 0 owns → enterPulse stays 0, X tracks code0.
- TIMEOUT_CYCLES=8, owner sends no pulses → timeout_flag=1 for exactly 1 cycle at the 8th idle cycle, then grant=00.
- lock_state forced to 011 during OWN → lockout=1, grant=00, all pulses blocked. lock_state→000 → RELEASE, then IDLE.
- Resetn pulsed low mid-OWN (asynchronously, between edges) → all outputs return to reset values immediately.
